edge_event_arbiter: RTL and testbench
=====================================

Name: edge_event_arbiter

Overview:
Multi-channel edge-event scheduler. Each of N_CH asynchronous inputs is synchronised and edge-detected (falling, rising or both). Detected events are latched as pending and shared, one at a time, onto a single valid/ready event port using round-robin arbitration. Per-channel sticky overflow flags record events lost while a channel was still pending. Sits between raw external strobes and the single event consumer (interrupt/status logic).

Parameters:
N_CH, 4, number of input channels (2..16)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
EDGE_SEL, 0, edge type: 0 falling, 1 rising, 2 both

Ports:
clk  in  1  system clock, rising-edge active
rst  in  1  asynchronous, active-low reset
din  in  N_CH  raw asynchronous channel inputs
en  in  N_CH  per-channel detection enable (synchronous)
evt_valid  out  1  event offered to consumer
evt_ready  in  1  consumer accepts event
evt_ch  out  $clog2(N_CH)  channel index of offered event
pending  out  N_CH  latched, not-yet-delivered events
overflow  out  N_CH  sticky lost-event flags
clr_ovf  in  N_CH  write-1-to-clear for overflow bits

Behaviour:
- Reset (rst=0, async): sync chains, prev-sample regs, pending, overflow = 0; evt_valid=0, evt_ch=0; FSM=IDLE; last_grant=N_CH-1 (channel 0 has first priority); warm-up counter loaded with SYNC_STAGES+1. Outputs change immediately on rst assertion, not at a clock edge.
- Synchroniser: din[i] passes through SYNC_STAGES flops giving cur[i]; prev[i] = cur[i] delayed 1 clk.
- Edge: falling = prev & ~cur; rising = ~prev & cur; both = prev ^ cur. Edge is ignored while the warm-up counter is nonzero. The counter decrements each clk after reset release, so no spurious edge results from the reset state.
- Latency (SYNC_STAGES=2): din transition sampled at clk edge k -> pending[i] set at edge k+3 -> evt_valid=1 after edge k+4 if FSM idle.
- Pending set: edge[i] & en[i] sets pending[i] next clk. If en[i]=0, the edge is dropped without overflow. Deasserting en does not clear pending.
- Overflow: edge[i] & en[i] while pending[i]=1, and that same cycle is not the accept of channel i -> overflow[i] set. Edge in the same cycle as the accept of channel i -> pending[i] stays 1 (new event), no overflow.
- clr_ovf[i]=1 clears overflow[i]. A simultaneous set has priority (bit stays 1).
- FSM IDLE: if |pending, select the first pending channel searching (last_grant+1) mod N_CH upward with wrap. Register evt_ch, assert evt_valid, go OFFER. Otherwise stay.
- FSM OFFER: evt_valid=1; evt_ch held stable while evt_ready=0 (no retraction, no re-arbitration). On evt_valid & evt_ready: clear pending[evt_ch], last_grant=evt_ch, evt_valid=0, go IDLE.
- Throughput: at most one event per 2 clks. evt_ready high in IDLE has no effect.
- Fairness: with all channels continuously pending, grants rotate 0,1,2,...,N_CH-1,0.
- Reset mid-OFFER: event is discarded, pending cleared, restart at channel-0 priority.

Test Plan:
- Reset/warm-up: rst=0 for 60 time units with din=all 1s, release (clk period 40) -> no pending, evt_valid=0, overflow=0 for 10 clks (EDGE_SEL=1 also yields no event).
- Single falling edge: din[2] 1->0 sampled at edge k, evt_ready=1 -> pending[2]=1 at k+3; evt_valid=1, evt_ch=2 at k+4; pending=0 after accept at k+5.
- Round-robin: din[3:0] all fall in the same cycle, evt_ready=1 -> evt_ch sequence 0,1,2,3, each valid for 1 clk, 2 clks apart. Then din[1] and din[0] fall together -> evt_ch=0 then 1 (last_grant was 3).
- Backpressure/overflow: evt_ready=0, din[1] falls, rises, falls again -> evt_valid held, evt_ch=1 stable; overflow[1]=1. clr_ovf[1] pulse -> overflow[1]=0. evt_ready=1 -> one event only.
- Enable/simultaneity: en[0]=0, din[0] falls -> no pending, no overflow. A second edge on ch2 timed to the accept cycle of ch2 -> pending[2] remains 1, overflow[2]=0, ch2 offered again.
- Async reset mid-OFFER: rst=0 between clk edges while evt_valid=1 -> evt_valid=0 and pending=0 immediately, before the next clk.

Source files
------------

// File: rtl/edge_event_arbiter_if.sv
// Event handshake between the edge arbiter and its single consumer.
// The master offers evt_ch with evt_valid; the slave takes it with evt_ready.
interface edge_event_arbiter_if #(
  parameter int N_CH = 4
) ();
  localparam int CH_W = $clog2(N_CH);

  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;

  modport master (output evt_valid, output evt_ch, input evt_ready);
  modport slave  (input evt_valid, input evt_ch, output evt_ready);
endinterface

// File: rtl/edge_event_arbiter.sv
// Synchronises N_CH strobes, detects edges, latches them as pending and serves them round-robin.
// Latency: din sampled at edge k -> pending at k+3 -> evt_valid after k+4 (SYNC_STAGES=2).
// Backpressure: offer held with a stable evt_ch until evt_ready; new edges on a pending channel set overflow.
module edge_event_arbiter #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_SEL    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     din,
  input  logic [N_CH-1:0]     en,
  input  logic [N_CH-1:0]     clr_ovf,
  output logic [N_CH-1:0]     pending,
  output logic [N_CH-1:0]     overflow,
  edge_event_arbiter_if.master evt
);
  localparam int CH_W = $clog2(N_CH);
  localparam int WU_W = $clog2(SYNC_STAGES + 2);
  localparam logic [WU_W-1:0] WU_INIT = WU_W'(SYNC_STAGES + 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  typedef enum logic {IDLE, OFFER} state_t;

  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] cur;
  logic [N_CH-1:0] prev_q;
  logic [N_CH-1:0] edge_raw;
  logic [N_CH-1:0] edge_q;
  logic [WU_W-1:0] warm_q;
  logic [N_CH-1:0] ev;
  logic            accept;
  logic [N_CH-1:0] accept_mask;
  state_t          state_q, state_nxt;
  logic [CH_W-1:0] ch_q, ch_nxt;
  logic [CH_W-1:0] last_q, last_nxt;
  logic [CH_W-1:0] pick;
  logic            pick_vld;

  // Multi-flop synchroniser per channel; cur is the last stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= din;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign cur = sync_q[SYNC_STAGES-1];

  // Raw edge of the selected type between the previous and current synchronised sample.
  always_comb begin
    edge_raw = '0;
    if (EDGE_SEL == 0)      edge_raw = prev_q & ~cur;
    else if (EDGE_SEL == 1) edge_raw = ~prev_q & cur;
    else                    edge_raw = prev_q ^ cur;
  end

  // Previous sample, warm-up countdown and registered edge pulse; the countdown masks
  // the artificial transitions produced while the chain fills from its reset value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= '0;
      warm_q <= WU_INIT;
      edge_q <= '0;
    end else begin
      prev_q <= cur;
      if (warm_q != '0) warm_q <= warm_q - 1'b1;
      edge_q <= (warm_q == '0) ? edge_raw : '0;
    end
  end

  assign ev          = edge_q & en;
  assign accept      = (state_q == OFFER) && evt.evt_ready;
  assign accept_mask = accept ? (N_CH'(1) << ch_q) : '0;

  // Pending set/clear and sticky overflow; a new edge coinciding with the accept of the
  // same channel re-arms pending instead of counting as a lost event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending  <= '0;
      overflow <= '0;
    end else begin
      pending  <= (pending & ~accept_mask) | ev;
      overflow <= (overflow & ~clr_ovf) | (ev & pending & ~accept_mask);
    end
  end

  // Round-robin search: first pending channel after last_q, wrapping around.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int off = 1; off <= N_CH; off++) begin
      idx = (int'(last_q) + off) % N_CH;
      if (!pick_vld && pending[idx]) begin
        pick_vld = 1'b1;
        pick     = CH_W'(idx);
      end
    end
  end

  // Offer FSM next state: grab a channel in IDLE, hold it in OFFER until accepted.
  always_comb begin
    state_nxt = state_q;
    ch_nxt    = ch_q;
    last_nxt  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          ch_nxt    = pick;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (evt.evt_ready) begin
          last_nxt  = ch_q;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Offer FSM registers; last_q starts at the top channel so channel 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      last_q  <= LAST_CH;
    end else begin
      state_q <= state_nxt;
      ch_q    <= ch_nxt;
      last_q  <= last_nxt;
    end
  end

  assign evt.evt_valid = (state_q == OFFER);
  assign evt.evt_ch    = ch_q;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter (N_CH=4, SYNC_STAGES=2, falling edges).
// Directed scenarios followed by random traffic, compared every cycle against an event-level model.
module tb_edge_event_arbiter;
  localparam int N_CH = 4;

  logic       clk = 1'b1;
  logic       rst;
  logic [3:0] din, en, clr_ovf;
  logic [3:0] pending, overflow;

  edge_event_arbiter_if #(.N_CH(N_CH)) evt_if ();

  edge_event_arbiter #(.N_CH(N_CH), .SYNC_STAGES(2), .EDGE_SEL(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .en       (en),
    .clr_ovf  (clr_ovf),
    .pending  (pending),
    .overflow (overflow),
    .evt      (evt_if.master)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;
  int acc0;
  int seen[$];

  // Model state: din history since reset release plus the abstract scheduler state.
  logic [3:0] hist[$];
  logic [3:0] m_pend, m_ovf;
  logic       m_off;
  int         m_ch, m_last;

  always @(posedge clk) if (rst && evt_if.evt_valid && evt_if.evt_ready) n_acc++;

  function automatic void model_reset();
    hist.delete();
    m_pend = '0;
    m_ovf  = '0;
    m_off  = 1'b0;
    m_ch   = 0;
    m_last = N_CH - 1;
  endfunction

  // A falling transition between two real din samples becomes an event three edges
  // after the second sample; applied at the current edge with the current inputs.
  function automatic void model_step();
    logic [3:0] ev, acc_mask;
    logic       acc, found;
    int         n;
    hist.push_back(din);
    n  = hist.size();
    ev = '0;
    if (n >= 5) ev = hist[n-5] & ~hist[n-4] & en;
    acc      = m_off && evt_if.evt_ready;
    acc_mask = acc ? (4'b0001 << m_ch) : 4'b0000;
    m_ovf    = (m_ovf & ~clr_ovf) | (ev & m_pend & ~acc_mask);
    if (m_off) begin
      if (acc) begin
        m_last = m_ch;
        m_off  = 1'b0;
      end
    end else if (m_pend != 0) begin
      found = 1'b0;
      for (int k = 1; k <= N_CH; k++) begin
        if (!found && m_pend[(m_last + k) % N_CH]) begin
          found = 1'b1;
          m_ch  = (m_last + k) % N_CH;
        end
      end
      m_off = 1'b1;
    end
    m_pend = (m_pend & ~acc_mask) | ev;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: model advances at the rising edge, outputs compared at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("valid", evt_if.evt_valid, m_off);
    if (m_off) check("ch", evt_if.evt_ch, m_ch);
    check("pending", pending, m_pend);
    check("overflow", overflow, m_ovf);
    if (evt_if.evt_valid) seen.push_back(int'(evt_if.evt_ch));
  endtask

  initial begin
    rst = 1'b0; din = 4'hF; en = 4'hF; clr_ovf = 4'h0; evt_if.evt_ready = 1'b0;
    model_reset();
    #1;
    check("rst_valid", evt_if.evt_valid, 1'b0);
    check("rst_ch", evt_if.evt_ch, 0);
    check("rst_pending", pending, 4'h0);
    check("rst_overflow", overflow, 4'h0);
    #59 rst = 1'b1;
    repeat (10) cycle();
    check("warm_pending", pending, 4'h0);
    check("warm_valid", evt_if.evt_valid, 1'b0);

    // Round robin from reset priority, then two channels after last grant 3.
    evt_if.evt_ready = 1'b1;
    seen.delete();
    din = 4'h0;
    repeat (12) cycle();
    check("rr_count", seen.size(), 4);
    for (int k = 0; k < 4; k++) check("rr_order", (k < seen.size()) ? seen[k] : 99, k);
    din = 4'hF;
    repeat (8) cycle();
    seen.delete();
    din = 4'b1100;
    repeat (10) cycle();
    check("rr2_count", seen.size(), 2);
    for (int k = 0; k < 2; k++) check("rr2_order", (k < seen.size()) ? seen[k] : 99, k);
    din = 4'hF;
    repeat (8) cycle();

    // Single falling edge on channel 2 with latency checks.
    din[2] = 1'b0;
    cycle();
    cycle();
    cycle();
    check("single_k2_pending", pending, 4'h0);
    cycle();
    check("single_k3_pending", pending, 4'b0100);
    check("single_k3_valid", evt_if.evt_valid, 1'b0);
    cycle();
    check("single_k4_valid", evt_if.evt_valid, 1'b1);
    check("single_k4_ch", evt_if.evt_ch, 2);
    cycle();
    check("single_k5_pending", pending, 4'h0);
    check("single_k5_valid", evt_if.evt_valid, 1'b0);
    din[2] = 1'b1;
    repeat (6) cycle();

    // Backpressure and overflow on channel 1.
    evt_if.evt_ready = 1'b0;
    din[1] = 1'b0; repeat (2) cycle();
    din[1] = 1'b1; repeat (2) cycle();
    din[1] = 1'b0; repeat (8) cycle();
    check("bp_overflow", overflow, 4'b0010);
    check("bp_valid", evt_if.evt_valid, 1'b1);
    check("bp_ch", evt_if.evt_ch, 1);
    clr_ovf = 4'b0010; cycle();
    clr_ovf = 4'b0000; cycle();
    check("clr_overflow", overflow, 4'h0);
    acc0 = n_acc;
    evt_if.evt_ready = 1'b1;
    repeat (6) cycle();
    check("bp_accepts", n_acc - acc0, 1);
    check("bp_pending", pending, 4'h0);
    din[1] = 1'b1;
    repeat (6) cycle();

    // Disabled channel drops its edge silently.
    en = 4'b1110;
    din[0] = 1'b0;
    repeat (8) cycle();
    check("en_pending", pending[0], 1'b0);
    check("en_overflow", overflow[0], 1'b0);
    en = 4'hF;
    din[0] = 1'b1;
    repeat (6) cycle();

    // Second edge on channel 2 lands on the accept cycle of channel 2.
    din[2] = 1'b0; cycle();
    din[2] = 1'b1; cycle();
    din[2] = 1'b0; cycle();
    cycle();
    cycle();
    check("sim_offer_valid", evt_if.evt_valid, 1'b1);
    check("sim_offer_ch", evt_if.evt_ch, 2);
    cycle();
    check("sim_pending", pending[2], 1'b1);
    check("sim_overflow", overflow[2], 1'b0);
    cycle();
    check("sim_reoffer_valid", evt_if.evt_valid, 1'b1);
    check("sim_reoffer_ch", evt_if.evt_ch, 2);
    din[2] = 1'b1;
    repeat (6) cycle();

    // Random traffic.
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 2) == 0) din = din ^ 4'($urandom);
      en               = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      clr_ovf          = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
      evt_if.evt_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    en = 4'hF; clr_ovf = 4'h0;

    // Asynchronous reset while an event is offered.
    evt_if.evt_ready = 1'b0;
    din = din & 4'b0111;
    for (int t = 0; t < 20 && !evt_if.evt_valid; t++) cycle();
    check("pre_reset_valid", evt_if.evt_valid, 1'b1);
    #5 rst = 1'b0;
    #1;
    check("arst_valid", evt_if.evt_valid, 1'b0);
    check("arst_pending", pending, 4'h0);
    check("arst_overflow", overflow, 4'h0);
    check("arst_ch", evt_if.evt_ch, 0);
    din = 4'hF;
    evt_if.evt_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (8) cycle();
    seen.delete();
    din = 4'b1010;
    repeat (8) cycle();
    check("restart_prio", (seen.size() > 0) ? seen[0] : 99, 0);
    for (int t = 0; t < 100; t++) begin
      if ($urandom_range(0, 2) == 0) din = din ^ 4'($urandom);
      evt_if.evt_ready = ($urandom_range(0, 1) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
